// File: rtl/reg_spill_fill.sv
// Register-file spill/fill sequencer: moves all 2**D registers to or from data
// memory one per cycle, starting at a latched base address.
module reg_spill_fill #(
  parameter int W = 8,
  parameter int D = 2,
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic         Dir,
  input  logic [A-1:0] BaseAddr,
  input  logic         Stall,
  output logic         Busy,
  output logic         Done,
  output logic [D-1:0] RfRaddr,
  input  logic [W-1:0] RfRdata,
  output logic         RfWriteEn,
  output logic [D-1:0] RfWaddr,
  output logic [W-1:0] RfWdata,
  output logic [A-1:0] MemAddr,
  output logic         MemWriteEn,
  output logic [W-1:0] MemWdata,
  input  logic [W-1:0] MemRdata
);

  localparam int N = 2 ** D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPILL = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state, state_nxt;
  logic [D-1:0] idx, idx_nxt;
  logic [A-1:0] base, base_nxt;
  logic [A-1:0] mem_addr;
  logic         last;

  assign mem_addr = base + A'(idx);
  assign last     = (idx == D'(N - 1));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      idx   <= '0;
      base  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      base  <= base_nxt;
    end
  end

  // Write enables are also gated by Reset_n so a reset aborts without a final write.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    base_nxt   = base;
    Busy       = 1'b0;
    Done       = 1'b0;
    RfRaddr    = '0;
    RfWriteEn  = 1'b0;
    RfWaddr    = '0;
    RfWdata    = '0;
    MemAddr    = '0;
    MemWriteEn = 1'b0;
    MemWdata   = '0;
    case (state)
      IDLE: begin
        if (Start) begin
          base_nxt  = BaseAddr;
          idx_nxt   = '0;
          state_nxt = Dir ? FILL : SPILL;
        end
      end
      SPILL: begin
        Busy       = 1'b1;
        RfRaddr    = idx;
        MemAddr    = mem_addr;
        MemWdata   = RfRdata;
        MemWriteEn = !Stall && Reset_n;
        if (!Stall) begin
          idx_nxt = idx + D'(1);
          if (last) state_nxt = DONE;
        end
      end
      FILL: begin
        Busy      = 1'b1;
        MemAddr   = mem_addr;
        RfWaddr   = idx;
        RfWdata   = MemRdata;
        RfWriteEn = !Stall && Reset_n;
        if (!Stall) begin
          idx_nxt = idx + D'(1);
          if (last) state_nxt = DONE;
        end
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_spill_fill.sv
// Bench for reg_spill_fill: behavioural register file and data memory around the
// DUT, directed scenarios followed by randomized transfers with random stalls.
module tb_reg_spill_fill;

  logic       Clk, Reset_n, Start, Dir, Stall;
  logic [7:0] BaseAddr;
  logic       Busy, Done, RfWriteEn, MemWriteEn;
  logic [1:0] RfRaddr, RfWaddr;
  logic [7:0] RfRdata, RfWdata, MemAddr, MemWdata, MemRdata;

  logic [7:0] mem [256];
  logic [7:0] rf [4];
  logic [7:0] pre_mem [256];
  logic [7:0] pre_rf [4];
  logic [7:0] exp_mem [256];
  logic [7:0] exp_rf [4];
  logic       load;
  int         done_count;
  int         checks, errors;

  reg_spill_fill #(.W(8), .D(2), .A(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Dir(Dir), .BaseAddr(BaseAddr),
    .Stall(Stall), .Busy(Busy), .Done(Done), .RfRaddr(RfRaddr), .RfRdata(RfRdata),
    .RfWriteEn(RfWriteEn), .RfWaddr(RfWaddr), .RfWdata(RfWdata), .MemAddr(MemAddr),
    .MemWriteEn(MemWriteEn), .MemWdata(MemWdata), .MemRdata(MemRdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign RfRdata  = rf[RfRaddr];
  assign MemRdata = mem[MemAddr];

  always @(posedge Clk) begin
    if (load) begin
      mem <= pre_mem;
      rf  <= pre_rf;
    end else begin
      if (MemWriteEn) mem[MemAddr] <= MemWdata;
      if (RfWriteEn) rf[RfWaddr] <= RfWdata;
    end
    if (Done) done_count <= done_count + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return {Busy, Done, RfRaddr, RfWriteEn, RfWaddr, RfWdata, MemAddr, MemWriteEn, MemWdata};
  endfunction

  task automatic do_load();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < 256; i++) pre_mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) pre_rf[i] = 8'($urandom);
    do_load();
  endtask

  // One complete transfer; the expected images and per-cycle outputs come from
  // the transfer count k and the snapshot taken before the operation starts.
  task automatic op(input logic dir, input logic [7:0] base, input int stall_pct,
                    input int stall_at, input int stall_len, input bit noise,
                    input int exp_done, input bit hold, input logic hdir,
                    input logic [7:0] hbase);
    int k, cyc, dc0, mdiff, rdiff;
    logic st;
    logic [7:0] a;
    exp_mem = mem;
    exp_rf  = rf;
    for (int i = 0; i < 4; i++) begin
      a = base + 8'(i);
      if (!dir) exp_mem[a] = rf[i];
      else exp_rf[i] = mem[a];
    end
    dc0 = done_count;
    Start = 1'b1; Dir = dir; BaseAddr = base; Stall = 1'b0;
    #1;
    check("idle_before_start", all_out(), 32'd0);
    step();
    k = 0; cyc = 0;
    while (k < 4 && cyc < 60) begin
      cyc++;
      if (noise) begin
        Start = 1'b1; Dir = 1'b1; BaseAddr = 8'h40;
      end else begin
        Start = 1'b0;
      end
      if (stall_len > 0) st = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      else st = ($urandom_range(0, 99) < stall_pct);
      Stall = st;
      #1;
      a = base + 8'(k);
      check("busy", 32'(Busy), 32'd1);
      check("done_early", 32'(Done), 32'd0);
      check("mem_addr", 32'(MemAddr), 32'(a));
      if (!dir) begin
        check("mem_we", 32'(MemWriteEn), 32'(!st));
        check("rf_raddr", 32'(RfRaddr), 32'(k));
        if (!st) check("mem_wdata", 32'(MemWdata), 32'(exp_rf[k]));
        check("spill_rf_idle", {21'd0, RfWriteEn, RfWaddr, RfWdata}, 32'd0);
      end else begin
        check("rf_we", 32'(RfWriteEn), 32'(!st));
        check("rf_waddr", 32'(RfWaddr), 32'(k));
        if (!st) check("rf_wdata", 32'(RfWdata), 32'(exp_mem[a]));
        check("fill_mem_idle", {21'd0, RfRaddr, MemWriteEn, MemWdata}, 32'd0);
      end
      if (!st) k++;
      step();
    end
    check("transfers", 32'(k), 32'd4);
    Start = hold; Dir = hdir; BaseAddr = hbase; Stall = 1'($urandom_range(0, 1));
    #1;
    check("done_pulse", 32'(Done), 32'd1);
    check("done_busy", 32'(Busy), 32'd0);
    check("done_we", {30'd0, MemWriteEn, RfWriteEn}, 32'd0);
    if (exp_done != 0) check("done_cycle", 32'(cyc + 1), 32'(exp_done));
    step();
    check("idle_after", all_out(), 32'd0);
    check("done_count", 32'(done_count - dc0), 32'd1);
    mdiff = 0; rdiff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) mdiff++;
    for (int i = 0; i < 4; i++) if (rf[i] !== exp_rf[i]) rdiff++;
    check("mem_image", 32'(mdiff), 32'd0);
    check("rf_image", 32'(rdiff), 32'd0);
  endtask

  initial begin
    int dc0;
    checks = 0; errors = 0; load = 1'b0;
    Reset_n = 1'b0; Start = 1'b0; Dir = 1'b0; BaseAddr = 8'h00; Stall = 1'b0;
    load_random();
    step();
    check("reset_outputs", all_out(), 32'd0);
    Reset_n = 1'b1;
    step();
    check("idle_outputs", all_out(), 32'd0);

    // Spill of a known register file to 0x10.
    pre_mem = mem;
    pre_rf[0] = 8'h11; pre_rf[1] = 8'h22; pre_rf[2] = 8'h33; pre_rf[3] = 8'h44;
    do_load();
    op(1'b0, 8'h10, 0, 0, 0, 1'b0, 5, 1'b0, 1'b0, 8'h00);
    check("spill_m10", 32'(mem[8'h10]), 32'h11);
    check("spill_m13", 32'(mem[8'h13]), 32'h44);

    // Fill across the top of the address space.
    pre_mem = mem; pre_rf = rf;
    pre_mem[8'hFE] = 8'hA1; pre_mem[8'hFF] = 8'hB2;
    pre_mem[8'h00] = 8'hC3; pre_mem[8'h01] = 8'hD4;
    do_load();
    op(1'b1, 8'hFE, 0, 0, 0, 1'b0, 5, 1'b0, 1'b0, 8'h00);
    check("fill_r0", 32'(rf[0]), 32'hA1);
    check("fill_r1", 32'(rf[1]), 32'hB2);
    check("fill_r2", 32'(rf[2]), 32'hC3);
    check("fill_r3", 32'(rf[3]), 32'hD4);

    // Two-cycle stall at the second transfer cycle.
    load_random();
    op(1'b0, 8'h20, 0, 2, 2, 1'b0, 7, 1'b0, 1'b0, 8'h00);

    // Start requests during a spill are ignored.
    load_random();
    op(1'b0, 8'h10, 0, 0, 0, 1'b1, 5, 1'b0, 1'b0, 8'h00);

    // Reset after two transfers.
    pre_mem = mem;
    for (int i = 0; i < 4; i++) begin
      pre_mem[8'h30 + i] = 8'h5A;
      pre_rf[i] = 8'($urandom_range(0, 255)) | 8'h01;
    end
    do_load();
    dc0 = done_count;
    Start = 1'b1; Dir = 1'b0; BaseAddr = 8'h30; Stall = 1'b0;
    step();
    Start = 1'b0;
    step();
    step();
    Reset_n = 1'b0;
    #1;
    check("reset_cycle_we", {30'd0, MemWriteEn, RfWriteEn}, 32'd0);
    step();
    check("reset_mid_outputs", all_out(), 32'd0);
    Reset_n = 1'b1;
    step();
    check("reset_mid_idle", all_out(), 32'd0);
    check("reset_m30", 32'(mem[8'h30]), 32'(pre_rf[0]));
    check("reset_m31", 32'(mem[8'h31]), 32'(pre_rf[1]));
    check("reset_m32", 32'(mem[8'h32]), 32'h5A);
    check("reset_m33", 32'(mem[8'h33]), 32'h5A);
    check("reset_no_done", 32'(done_count - dc0), 32'd0);

    // Start held through DONE: the next fill starts after one idle cycle.
    load_random();
    op(1'b0, 8'h80, 0, 0, 0, 1'b0, 5, 1'b1, 1'b1, 8'h81);
    op(1'b1, 8'h81, 0, 0, 0, 1'b0, 5, 1'b0, 1'b0, 8'h00);

    // Randomized transfers with random stalls.
    for (int n = 0; n < 10; n++) begin
      load_random();
      op(1'($urandom_range(0, 1)), 8'($urandom), 30, 0, 0, 1'b0, 0, 1'b0, 1'b0, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
